// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the MEM stage and its MEM/WB register.
//   DATA_W / REG_W : default datapath and register-index widths
//   mem_state_t    : data-memory access FSM states
//   mem_wb_t       : MEM/WB pipeline bundle handed to the writeback stage
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    MS_IDLE,
    MS_BUSY
  } mem_state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_out;
    logic [REG_W-1:0]  write_reg;
  } mem_wb_t;

endpackage

// File: rtl/latch_d.sv
// MEM/WB pipeline register.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the whole bundle
//   bubble : load a bubble (write/load flags cleared, data fields held)
//   d      : bundle captured when not bubbling
//   q      : registered bundle
module latch_d
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  mem_wb_t q_q;
  mem_wb_t q_d;

  always_comb begin
    q_d = d;
    if (bubble) begin
      q_d            = q_q;
      q_d.reg_write  = 1'b0;
      q_d.mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: resolves the branch select and performs the data-memory
// access over a req/ready handshake, stalling upstream until the memory
// answers or MAX_WAIT wait cycles elapse (then the access is aborted and
// BusErrM is set sticky). Results are registered into MEM/WB via latch_d.
//   EX/MEM inputs : RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM,
//                   ALUOutM, WriteDataM, WriteRegM, PCBranchM
//   Branch        : PCSrcM, PCBranchOut (combinational, never stalled)
//   Pipeline      : StallM freezes PC, IF/ID, ID/EX and EX/MEM
//   Data memory   : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ready,
//                   dmem_rdata; BusErrM sticky timeout flag
//   MEM/WB        : RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
// Optional: define MEM_ALIGN_CHECK_EN to suppress misaligned accesses
// (ALUOutM[1:0] != 0) and flag them on the sticky AlignErrM output.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int REG_W    = cpu_pkg::REG_W,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              BranchM,
  input  logic              ZeroM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [DATA_W-1:0] PCBranchM,
  output logic              PCSrcM,
  output logic [DATA_W-1:0] PCBranchOut,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              BusErrM,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              AlignErrM,
`endif
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic    memop, misalign, issue, busy, timeout, done, abort;
  mem_wb_t wb_d, wb_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  assign misalign  = memop & (ALUOutM[1:0] != 2'b00);
  assign AlignErrM = align_err_q;
`else
  assign misalign = 1'b0;
`endif

  assign PCSrcM      = BranchM & ZeroM;
  assign PCBranchOut = PCBranchM;
  assign dmem_we     = MemWriteM;
  assign dmem_addr   = ALUOutM;
  assign dmem_wdata  = WriteDataM;
  assign BusErrM     = bus_err_q;

  always_comb begin
    memop   = MemtoRegM | MemWriteM;
    issue   = memop & ~misalign;
    busy    = (state_q == MS_BUSY);
    timeout = busy & (cnt_q == CNT_W'(MAX_WAIT));
    // Reset kills an outstanding request in the same cycle.
    dmem_req = ~rst & (busy | issue);
    done     = dmem_req & dmem_ready;
    // A late ready on the final wait cycle still completes normally.
    StallM   = dmem_req & ~dmem_ready & ~timeout;
    abort    = ~rst & timeout & ~dmem_ready;

    state_d   = MS_IDLE;
    cnt_d     = '0;
    bus_err_d = bus_err_q | abort;
    if (StallM) begin
      state_d = MS_BUSY;
      cnt_d   = busy ? cnt_q + 1'b1 : CNT_W'(1);
    end

    wb_d.reg_write  = RegWriteM & ~abort & ~misalign;
    wb_d.mem_to_reg = MemtoRegM;
    wb_d.read_data  = done ? dmem_rdata : '0;
    wb_d.alu_out    = ALUOutM;
    wb_d.write_reg  = WriteRegM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_d = align_err_q | misalign;

  always_ff @(posedge clk) begin
    if (rst) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end
`endif

  latch_d u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (StallM),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign RegWriteW = wb_q.reg_write;
  assign MemtoRegW = wb_q.mem_to_reg;
  assign ReadDataW = wb_q.read_data;
  assign ALUOutW   = wb_q.alu_out;
  assign WriteRegW = wb_q.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// transactions against a transaction-level model (stall length, error flags
// and writeback contents computed per instruction from latency rules).
module tb_mem_stage;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
  logic [31:0] ALUOutM, WriteDataM, PCBranchM;
  logic [4:0]  WriteRegM;
  logic        PCSrcM;
  logic [31:0] PCBranchOut;
  logic        StallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        BusErrM;
`ifdef MEM_ALIGN_CHECK_EN
  logic        AlignErrM;
`endif
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        m_bus_err   = 1'b0;
  logic        m_align_err = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchM(BranchM), .ZeroM(ZeroM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .PCBranchM(PCBranchM),
    .PCSrcM(PCSrcM), .PCBranchOut(PCBranchOut), .StallM(StallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .BusErrM(BusErrM),
`ifdef MEM_ALIGN_CHECK_EN
    .AlignErrM(AlignErrM),
`endif
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the W capture edge.
  // lat = cycles from first request cycle until ready (> MAXW: never).
  task automatic run_txn(input logic rw, input logic m2r, input logic mw,
                         input logic br, input logic z,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pcb, input logic [4:0] wr,
                         input int unsigned lat, input logic [31:0] rd,
                         input logic stray_ready);
    logic        memop, mis, req_op, err;
    int unsigned n;
    memop  = m2r | mw;
`ifdef MEM_ALIGN_CHECK_EN
    mis    = memop && (alu % 4 != 0);
`else
    mis    = 1'b0;
`endif
    req_op = memop && !mis;
    err    = req_op && (lat > MAXW);
    n      = !req_op ? 0 : (lat < MAXW ? lat : MAXW);

    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; BranchM = br; ZeroM = z;
    ALUOutM = alu; WriteDataM = wd; PCBranchM = pcb; WriteRegM = wr;

    for (int unsigned i = 0; i <= n; i++) begin
      dmem_ready = req_op ? (i == lat) : stray_ready;
      dmem_rdata = dmem_ready ? rd : $urandom;
      #3;
      check_eq("pcsrc", PCSrcM, br & z);
      check_eq("pcbranch", PCBranchOut, pcb);
      check_eq("req", dmem_req, req_op);
      check_eq("stall", StallM, i < n);
      if (req_op) begin
        check_eq("addr", dmem_addr, alu);
        check_eq("we", dmem_we, mw);
        check_eq("wdata", dmem_wdata, wd);
      end
      @(posedge clk); #1;
      if (i < n) begin
        check_eq("bubble_rw", RegWriteW, 0);
        check_eq("bubble_m2r", MemtoRegW, 0);
      end
    end
    dmem_ready = 1'b0;

    if (err) m_bus_err = 1'b1;
    if (mis) m_align_err = 1'b1;
    check_eq("w_regwrite", RegWriteW, rw && !err && !mis);
    check_eq("w_memtoreg", MemtoRegW, m2r);
    if (!err) check_eq("w_readdata", ReadDataW, req_op ? rd : 32'h0);
    check_eq("w_aluout", ALUOutW, alu);
    check_eq("w_writereg", WriteRegW, wr);
    check_eq("buserr", BusErrM, m_bus_err);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("alignerr", AlignErrM, m_align_err);
`endif
  endtask

  task automatic check_w_zero(input string tag);
    check_eq({tag, "_rw"}, RegWriteW, 0);
    check_eq({tag, "_m2r"}, MemtoRegW, 0);
    check_eq({tag, "_rd"}, ReadDataW, 0);
    check_eq({tag, "_alu"}, ALUOutW, 0);
    check_eq({tag, "_wr"}, WriteRegW, 0);
    check_eq({tag, "_buserr"}, BusErrM, 0);
  endtask

  initial begin
    rst = 1'b1;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; BranchM = 0; ZeroM = 0;
    ALUOutM = '0; WriteDataM = '0; PCBranchM = '0; WriteRegM = '0;
    dmem_ready = 0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_w_zero("reset");
    MemtoRegM = 1'b1;
    #3;
    check_eq("reset_req", dmem_req, 0);
    check_eq("reset_stall", StallM, 0);
    MemtoRegM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op, load with 3 wait cycles, zero-wait store, branch
    run_txn(1, 0, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    run_txn(1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF, 1'b0);
    run_txn(0, 0, 1, 0, 0, 32'h200, 32'hA5A5A5A5, 32'h0, 5'd0, 0, 32'h0, 1'b0);
    run_txn(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0, 1'b1);
    // Ready on the last possible wait cycle, then a timeout
    run_txn(1, 1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 5'd3, MAXW, 32'h600DF00D, 1'b0);
    run_txn(1, 1, 0, 0, 0, 32'h104, 32'h0, 32'h0, 5'd9, MAXW + 4, 32'h0, 1'b0);
    // BusErrM stays sticky across a later good instruction
    run_txn(1, 0, 0, 0, 1, 32'h55, 32'h0, 32'h8, 5'd2, 0, 32'h0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    run_txn(1, 1, 0, 0, 0, 32'h102, 32'h0, 32'h0, 5'd4, 2, 32'h12345678, 1'b0);
`endif

    // Reset in the second BUSY cycle
    RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; ALUOutM = 32'h400; WriteRegM = 5'd6;
    dmem_ready = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      #3;
      check_eq("busy_stall", StallM, 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #3;
    check_eq("rst_busy_req", dmem_req, 0);
    check_eq("rst_busy_stall", StallM, 0);
    @(posedge clk); #1;
    m_bus_err = 1'b0; m_align_err = 1'b0;
    check_w_zero("rst_busy");
    MemtoRegM = 0;
    rst = 1'b0;
    run_txn(1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd1, 0, 32'h0, 1'b0);

    // Randomized instruction stream
    for (int unsigned t = 0; t < 80; t++) begin
      int unsigned kind, lat;
      kind = $urandom_range(0, 2);
      lat  = ($urandom_range(0, 7) == 0) ? MAXW + 2 : $urandom_range(0, 5);
      run_txn($urandom_range(0, 1) == 1, kind == 1, kind == 2,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom, $urandom, $urandom, 5'($urandom), lat, $urandom,
              $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branch select and performs the data-memory access over a ready/request handshake to a variable-latency data memory.
- Stalls upstream while an access is outstanding, then registers results into the MEM/WB boundary for writeback.
- Sits between the EX/MEM latch and the WB stage / register file.

Parameters:
- DATA_W, 32, data and address width
- REG_W, 5, register-index width
- MAX_WAIT, 16, maximum wait cycles for dmem_ready before the access is aborted (must be ≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- RegWriteM  in  1  register write enable from the EX/MEM register
- MemtoRegM  in  1  load instruction flag
- MemWriteM  in  1  store instruction flag
- BranchM  in  1  branch instruction flag
- ZeroM  in  1  ALU zero flag
- ALUOutM  in  DATA_W  ALU result; used as memory address
- WriteDataM  in  DATA_W  store data
- WriteRegM  in  REG_W  destination register index
- PCBranchM  in  DATA_W  branch target
- PCSrcM  out  1  branch taken = BranchM & ZeroM
- PCBranchOut  out  DATA_W  = PCBranchM
- StallM  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers
- dmem_req  out  1  memory request
- dmem_we  out  1  write strobe, valid with dmem_req
- dmem_addr  out  DATA_W  = ALUOutM
- dmem_wdata  out  DATA_W  = WriteDataM
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready
- BusErrM  out  1  sticky timeout flag
- RegWriteW  out  1  registered writeback enable
- MemtoRegW  out  1  registered load flag
- ReadDataW  out  DATA_W  registered load data
- ALUOutW  out  DATA_W  registered ALU result
- WriteRegW  out  REG_W  registered destination register

Behaviour:
- Reset: clk and rst are as already decided — one clock; reset is synchronous and active-high.
  - At reset, state = IDLE, wait counter = 0, BusErrM = 0.
  - All W outputs are cleared to 0.
  - While rst is high, dmem_req = 0 and StallM = 0.
- Memory op: memop = MemtoRegM | MemWriteM. dmem_we = MemWriteM.
- FSM, states IDLE and BUSY:
  - IDLE, memop = 0: no request. W registers capture the M inputs next edge (1-cycle latency). ReadDataW = 0.
  - IDLE, memop = 1: dmem_req = 1 combinationally.
    - dmem_ready = 1 in the same cycle: zero-wait completion, StallM = 0, W captures next edge.
    - Otherwise: StallM = 1, go to BUSY, counter = 1.
  - BUSY: dmem_req = 1 and StallM = 1. Address, write data and write strobe stay stable, since the upstream is frozen.
    - dmem_ready = 1: StallM = 0 this cycle, W captures with ReadDataW = dmem_rdata, go to IDLE, counter cleared.
    - counter == MAX_WAIT with no ready: abort. StallM = 0, BusErrM set, W captures with RegWriteW forced 0, go to IDLE.
    - Otherwise: counter increments.
- While StallM = 1, the W registers load a bubble: RegWriteW = 0, MemtoRegW = 0, other fields don't-care (held).
- Store completion: RegWriteW follows RegWriteM; normally 0 for a store.
- dmem_ready while dmem_req = 0 is ignored.
- Reset during BUSY: the request drops immediately, state returns to IDLE, and no W capture takes place.
- BusErrM is cleared only by rst.
- PCSrcM and PCBranchOut are purely combinational and never gated by the stall.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined: a memop with ALUOutM[1:0] != 0 issues no request and causes no stall. The instruction completes in 1 cycle with RegWriteW = 0. The extra output AlignErrM (1 bit) is set sticky and cleared by rst.
- When undefined: no check is made, the AlignErrM port is absent, and misaligned addresses go to memory unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - constants DATA_W = 32 and REG_W = 5;
  - enum mem_state_t {MS_IDLE, MS_BUSY};
  - a typedef for the MEM/WB bundle (RegWrite, MemtoReg, ReadData, ALUOut, WriteReg).
- One natural sub-module: latch_d, the MEM/WB register with synchronous reset and a bubble input, instantiated by mem_stage.

Test Plan:
- ALU op, RegWriteM = 1, ALUOutM = 0x1234, WriteRegM = 5 -> after 1 edge: RegWriteW = 1, ALUOutW = 0x1234, WriteRegW = 5; StallM and dmem_req stay 0.
- Load from 0x100, memory ready after 3 cycles with rdata 0xDEADBEEF -> StallM high for 3 cycles, dmem_req held with addr 0x100, then ReadDataW = 0xDEADBEEF, MemtoRegW = 1; bubbles (RegWriteW = 0) during the stall.
- Store with zero-wait ready (WriteDataM = 0xA5A5A5A5) -> dmem_req = 1 and dmem_we = 1 for 1 cycle, StallM = 0.
- Load with ready never asserted, MAX_WAIT = 16 -> StallM drops after 16 wait cycles, BusErrM = 1, RegWriteW = 0, BusErrM stays set until rst.
- rst asserted in the 2nd BUSY cycle -> same cycle: dmem_req = 0, StallM = 0; next edge: W outputs 0, FSM IDLE.
- BranchM = 1, ZeroM = 1, PCBranchM = 0x40 -> PCSrcM = 1 and PCBranchOut = 0x40 combinationally. With MEM_ALIGN_CHECK_EN defined, a load at 0x102 -> no request, AlignErrM = 1.
